imem_loader: RTL
================

# imem_loader

Boot-time program loader upstream of the single-cycle core's instruction cache. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the instruction memory's write port at consecutive word addresses. It holds the core in reset via `core_hold` until the image is complete, then releases it. A `load_req` pulse re-enters loading for a reload.

## Interface
- `BASE_ADDR`, 0: word address of the first instruction written. The core's PC is word-addressed (increments by 1).
- `MAX_WORDS`, 1024: largest accepted image length, in words.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `load_req` in 1: single-cycle reload request.
- `imem_en` out 1: instruction memory port enable; equal to `imem_we`.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out 32: word address.
- `imem_wdata` out 32: instruction word.
- `core_hold` out 1: 1 holds the core in reset. The top combines it with its own reset.
- `load_done` out 1: image loaded; core running.
- `load_err` out 1: header rejected.
- `words_loaded` out 16: count of words written in the current load.

## Operation
- **Stream format:** 2 header bytes giving N (16-bit, MSB first), followed by N words of 4 bytes each, MSB first.
- **Byte transfer:** a byte transfers only on a rising edge where `rx_valid && rx_ready`.
- **States:** HDR_HI, HDR_LO, BYTE, WRITE, RUN, ERR.
- **HDR_HI:** `rx_ready=1`. On transfer, latch N[15:8], then go to HDR_LO.
- **HDR_LO:** `rx_ready=1`. On transfer, latch N[7:0].
  - If N==0 or N>MAX_WORDS, go to ERR.
  - Otherwise go to BYTE, with byte_idx=0 and word_idx=0.
- **BYTE:** `rx_ready=1`. On transfer, shift the byte into the assembly register: `asm <= {asm[23:0], rx_data}`, and increment byte_idx (2 bits).
  - On the transfer with byte_idx==3, go to WRITE.
- **WRITE:** `rx_ready=0`.
  - Drive `imem_we=1`, `imem_addr=BASE_ADDR+word_idx`, `imem_wdata=asm`.
  - Increment word_idx and `words_loaded`.
  - If word_idx==N-1, go to RUN; otherwise go to BYTE.
- **RUN:** `rx_ready=0`, `core_hold=0`, `load_done=1`. Bytes arriving in RUN are not accepted.
- **ERR:** `rx_ready=0`, `core_hold=1`, `load_err=1`. ERR is sticky until `load_req` or reset.
- **load_req in RUN or ERR:** go to HDR_HI next cycle.
  - Set `core_hold=1`, clear `load_done`, `load_err` and `words_loaded`.
  - Instruction memory contents are left untouched.
- **load_req in any other state:** ignored.
- **Address arithmetic:** `BASE_ADDR+word_idx` in 32 bits, no wrap check. Keeping it in range is the integrator's responsibility.

## Timing
- **Reset values:** state=HDR_HI, `rx_ready=1`, `core_hold=1`, `imem_en=imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `load_done=0`, `load_err=0`, `words_loaded=0`.
- **Reset mid-operation:** immediate return to the reset values. A partially assembled word is discarded and never written.
- **Registered outputs:** `imem_*`, `core_hold`, `load_done`, `load_err` and `words_loaded` are all registered. `rx_ready` is decoded from the state register.
- **Write pulse:** `imem_we` is high for exactly the one cycle spent in WRITE.
- **Best-case throughput:** one word per 5 cycles (4 transfers + 1 write cycle).
- **Back-pressure:** `rx_valid` gaps only stall the loader. No timeout.
- **Release latency:** `core_hold` falls on the edge that enters RUN, i.e. the cycle after the last write. The memory write therefore completes before the core fetches.
- **Reload latency:** after a `load_req` sampled in RUN or ERR, `core_hold` is 1 on the following cycle.

## Structure
- **Shared package `risc_loader_pkg`:**
  - state enum `loader_state_t` (6 states);
  - `HDR_BYTES=2`;
  - `WORD_BYTES=4`.
- **Sub-module `word_assembler`:**
  - 4-byte shift register plus 2-bit byte counter, with `push`, `clear`, `full` and `word` ports;
  - instantiated once; the FSM stays in `imem_loader`.

## Test plan
- **Reset values:** assert `reset`=0 mid-run, then release → every output matches its listed reset value; `rx_ready=1` on the first cycle after release.
- **Two-word load:** stream 00 02 12 34 56 78 9A BC DE F0 with continuous valid.
  - Writes: addr 0 ← 0x12345678, then addr 1 ← 0x9ABCDEF0, each with `imem_we` high for 1 cycle.
  - Then `core_hold=0`, `load_done=1`, `words_loaded=2`.
- **Bad headers:** header 00 00 → ERR, `load_err=1`, `core_hold=1`, no writes. Repeat with N=MAX_WORDS+1 → same result.
- **Back-pressure:** insert random 0–5 cycle `rx_valid` gaps during the two-word load → identical writes and final state; no byte lost or duplicated.
- **Reload:** pulse `load_req` in RUN → `core_hold=1` next cycle; a new one-word image lands at BASE_ADDR and `load_done` reasserts. A `load_req` pulsed during BYTE is ignored.
- **Reset mid-word:** assert reset after 2 of 4 word bytes → no write; after release, a fresh header is required.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package risc_loader_pkg;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BIDX_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_BYTE,
        ST_WRITE,
        ST_RUN,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction memory write port of the loader.
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_en;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    // Loader side
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_en,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    // Stream source / memory side
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_en,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Big-endian word assembler: shifts bytes in MSB first and counts them.
module word_assembler
    import risc_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      clear,
    input  logic [7:0]                data,
    output logic                      full,
    output logic [8*WORD_BYTES-1:0]   word
);

    logic [8*WORD_BYTES-1:0] r_word;
    logic [BIDX_W-1:0]       r_cnt;

    // Shift register and byte counter; the counter wraps after the last byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (push) begin
            r_word <= {r_word[8*WORD_BYTES-9:0], data};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // full: the next push completes the word
    assign full = (r_cnt == BIDX_W'(WORD_BYTES - 1));
    assign word = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction words,
// writes them to instruction memory and holds the core until done.
module imem_loader
    import risc_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus,
    input  logic          load_req,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_err,
    output logic [15:0]   words_loaded
);

    loader_state_t r_state;
    loader_state_t w_next_state;

    logic        w_rx_ready;
    logic        w_xfer;
    logic        w_push;
    logic        w_clear;
    logic        w_full;
    logic        w_reload;
    logic        w_hdr_bad;
    logic [15:0] w_n;

    logic [7:0]  r_n_hi;
    logic [15:0] r_n_words;
    logic [15:0] r_word_idx;
    logic [15:0] r_words_loaded;
    logic        r_imem_we;
    logic [31:0] r_imem_addr;
    logic        r_core_hold;
    logic        r_load_done;
    logic        r_load_err;

    assign w_xfer    = bus.rx_valid && w_rx_ready;
    assign w_n       = {r_n_hi, bus.rx_data};
    assign w_hdr_bad = (w_n == 16'd0) || (32'(w_n) > MAX_WORDS);
    assign w_reload  = load_req && ((r_state == ST_RUN) || (r_state == ST_ERR));

    word_assembler u_asm (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .clear (w_clear),
        .data  (bus.rx_data),
        .full  (w_full),
        .word  (bus.imem_wdata)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HDR_HI;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_HDR_HI: if (w_xfer) w_next_state = ST_HDR_LO;
            ST_HDR_LO: if (w_xfer) w_next_state = w_hdr_bad ? ST_ERR : ST_BYTE;
            ST_BYTE:   if (w_xfer && w_full) w_next_state = ST_WRITE;
            ST_WRITE:  w_next_state = (r_word_idx == r_n_words - 16'd1) ? ST_RUN : ST_BYTE;
            ST_RUN,
            ST_ERR:    if (load_req) w_next_state = ST_HDR_HI;
            default:   w_next_state = ST_HDR_HI;
        endcase
    end

    // Decoded handshake and assembler controls
    always_comb begin
        w_rx_ready = 1'b0;
        w_push     = 1'b0;
        w_clear    = 1'b0;
        unique case (r_state)
            ST_HDR_HI: w_rx_ready = 1'b1;
            ST_HDR_LO: begin
                w_rx_ready = 1'b1;
                w_clear    = bus.rx_valid;
            end
            ST_BYTE: begin
                w_rx_ready = 1'b1;
                w_push     = bus.rx_valid;
            end
            default: w_rx_ready = 1'b0;
        endcase
    end

    // Header capture and word / load counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n_hi         <= '0;
            r_n_words      <= '0;
            r_word_idx     <= '0;
            r_words_loaded <= '0;
        end else begin
            if ((r_state == ST_HDR_HI) && w_xfer) begin
                r_n_hi <= bus.rx_data;
            end
            if ((r_state == ST_HDR_LO) && w_xfer) begin
                r_n_words  <= w_n;
                r_word_idx <= '0;
            end
            if (r_state == ST_WRITE) begin
                r_word_idx     <= r_word_idx + 16'd1;
                r_words_loaded <= r_words_loaded + 16'd1;
            end
            if (w_reload) begin
                r_words_loaded <= '0;
            end
        end
    end

    // Registered outputs follow the state being entered so they line up with it;
    // imem_wdata is the assembler register itself, which holds the word during WRITE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_imem_we   <= 1'b0;
            r_imem_addr <= '0;
            r_core_hold <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_imem_we   <= (w_next_state == ST_WRITE);
            if (w_next_state == ST_WRITE) begin
                r_imem_addr <= BASE_ADDR + 32'(r_word_idx);
            end
            r_core_hold <= (w_next_state != ST_RUN);
            r_load_done <= (w_next_state == ST_RUN);
            r_load_err  <= (w_next_state == ST_ERR);
        end
    end

    assign bus.rx_ready  = w_rx_ready;
    assign bus.imem_we   = r_imem_we;
    assign bus.imem_en   = r_imem_we;
    assign bus.imem_addr = r_imem_addr;
    assign core_hold     = r_core_hold;
    assign load_done     = r_load_done;
    assign load_err      = r_load_err;
    assign words_loaded  = r_words_loaded;

endmodule
